// File: rtl/uart_flow_sched.sv
// uart_flow_sched: modem-pin synchronizers, auto-RTS hysteresis, CTS-gated TX frame grants and MSR tracking.
// Define UART_FLOW_SCHED_MSI_EN to build the MSR delta bits and the modem-status interrupt.

module uart_flow_sched #(
  parameter int FIFO_DEPTH  = 32,
  parameter int LVL_W       = $clog2(FIFO_DEPTH + 1),
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cr_uarten_i,
  input  logic             cr_rtsen_i,
  input  logic             cr_ctsen_i,
  input  logic             cr_rts_i,
  input  logic             cr_dtr_i,
  input  logic [LVL_W-1:0] cr_rx_hi_i,
  input  logic [LVL_W-1:0] cr_rx_lo_i,
  input  logic [LVL_W-1:0] rx_fifo_lvl_i,
  input  logic             tx_start_req_i,
  input  logic             tx_busy_i,
  output logic             tx_start_gnt_o,
  input  logic             uart_cts_ni,
  input  logic             uart_dsr_ni,
  input  logic             uart_ri_ni,
  input  logic             uart_dcd_ni,
  output logic             uart_rts_no,
  output logic             uart_dtr_no,
  output logic [7:0]       msr_o,
  input  logic             msr_rd_i,
  output logic             msi_o
);

  typedef enum logic {RTS_ON, RTS_OFF} rts_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_GRANT, TX_BUSY} tx_state_e;

  logic [3:0]                  pins_n;
  logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]                  lvl_s;
  logic [3:0]                  delta;
  logic                        cts_s;

  rts_state_e rts_state_q, rts_state_d;
  tx_state_e  tx_state_q, tx_state_d;
  logic       rts_no_q, rts_no_d;
  logic       dtr_no_q, dtr_no_d;
  logic       tx_gnt;

  // Bit order matches the MSR upper nibble: {dcd, ri, dsr, cts}.
  assign pins_n = {uart_dcd_ni, uart_ri_ni, uart_dsr_ni, uart_cts_ni};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pins_n[i]};
      lvl_s[i]  = ~sync_q[i][SYNC_STAGES-1];
    end
  end

  assign cts_s = lvl_s[0];

  always_comb begin
    rts_state_d = rts_state_q;
    case (rts_state_q)
      RTS_ON:  if (rx_fifo_lvl_i >= cr_rx_hi_i) rts_state_d = RTS_OFF;
      // Requiring lvl < hi keeps a mis-programmed lo >= hi from toggling every cycle.
      RTS_OFF: if (rx_fifo_lvl_i <= cr_rx_lo_i && rx_fifo_lvl_i < cr_rx_hi_i) rts_state_d = RTS_ON;
      default: rts_state_d = RTS_ON;
    endcase
    if (!cr_uarten_i || !cr_rtsen_i) rts_state_d = RTS_ON;
    rts_no_d = ~(cr_rtsen_i ? (rts_state_q == RTS_ON) : cr_rts_i);
    dtr_no_d = ~cr_dtr_i;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_gnt     = 1'b0;
    case (tx_state_q)
      TX_IDLE:  if (tx_start_req_i && (!cr_ctsen_i || cts_s)) tx_state_d = TX_GRANT;
      TX_GRANT: begin
        tx_gnt     = 1'b1;
        tx_state_d = TX_BUSY;
      end
      TX_BUSY:  if (!tx_busy_i) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
    if (!cr_uarten_i) begin
      tx_state_d = TX_IDLE;
      tx_gnt     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q      <= '1;
      rts_state_q <= RTS_ON;
      tx_state_q  <= TX_IDLE;
      rts_no_q    <= 1'b1;
      dtr_no_q    <= 1'b1;
    end else begin
      sync_q      <= sync_d;
      rts_state_q <= rts_state_d;
      tx_state_q  <= tx_state_d;
      rts_no_q    <= rts_no_d;
      dtr_no_q    <= dtr_no_d;
    end
  end

`ifdef UART_FLOW_SCHED_MSI_EN
  logic [3:0] lvl_prev_q, lvl_prev_d;
  logic [3:0] delta_q, delta_d;
  logic [3:0] chg;
  logic       msi_q, msi_d;

  // TERI only flags the trailing edge of ring (ri_s 1->0); a new change beats a coincident read.
  always_comb begin
    lvl_prev_d = lvl_s;
    chg        = lvl_s ^ lvl_prev_q;
    chg[2]     = lvl_prev_q[2] & ~lvl_s[2];
    delta_d    = (msr_rd_i ? 4'b0000 : delta_q) | chg;
    msi_d      = |delta_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lvl_prev_q <= 4'b0000;
      delta_q    <= 4'b0000;
      msi_q      <= 1'b0;
    end else begin
      lvl_prev_q <= lvl_prev_d;
      delta_q    <= delta_d;
      msi_q      <= msi_d;
    end
  end

  assign delta = delta_q;
  assign msi_o = msi_q;
`else
  logic unused_msr_rd;

  assign unused_msr_rd = msr_rd_i;
  assign delta         = 4'b0000;
  assign msi_o         = 1'b0;
`endif

  assign msr_o          = {lvl_s, delta};
  assign uart_rts_no    = rts_no_q;
  assign uart_dtr_no    = dtr_no_q;
  assign tx_start_gnt_o = tx_gnt;

endmodule

// File: tb/tb_uart_flow_sched.sv
// Scoreboard bench for uart_flow_sched: expectations are queued with a target cycle when stimulus is driven.
// Grants are checked every cycle against a queue of expected grant cycles.

module tb_uart_flow_sched;

  localparam int LVL_W = 6;

`ifdef UART_FLOW_SCHED_MSI_EN
  localparam logic [7:0] DM    = 8'hFF;
  localparam logic [7:0] MSI_V = 8'h01;
`else
  localparam logic [7:0] DM    = 8'h00;
  localparam logic [7:0] MSI_V = 8'h00;
`endif

  localparam int SEL_RTS = 0;
  localparam int SEL_DTR = 1;
  localparam int SEL_MSR = 2;
  localparam int SEL_MSI = 3;

  logic             clk;
  logic             rst_ni;
  logic             cr_uarten, cr_rtsen, cr_ctsen, cr_rts, cr_dtr;
  logic [LVL_W-1:0] cr_rx_hi, cr_rx_lo, rx_fifo_lvl;
  logic             tx_start_req, tx_busy, tx_start_gnt;
  logic             cts_n, dsr_n, ri_n, dcd_n;
  logic             uart_rts_no, uart_dtr_no;
  logic [7:0]       msr;
  logic             msr_rd, msi;

  typedef struct packed {
    int         at;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int   gntq[$];
  int   cyc = 0;
  int   check_count = 0;
  int   pass_count = 0;

  uart_flow_sched dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .cr_uarten_i    (cr_uarten),
    .cr_rtsen_i     (cr_rtsen),
    .cr_ctsen_i     (cr_ctsen),
    .cr_rts_i       (cr_rts),
    .cr_dtr_i       (cr_dtr),
    .cr_rx_hi_i     (cr_rx_hi),
    .cr_rx_lo_i     (cr_rx_lo),
    .rx_fifo_lvl_i  (rx_fifo_lvl),
    .tx_start_req_i (tx_start_req),
    .tx_busy_i      (tx_busy),
    .tx_start_gnt_o (tx_start_gnt),
    .uart_cts_ni    (cts_n),
    .uart_dsr_ni    (dsr_n),
    .uart_ri_ni     (ri_n),
    .uart_dcd_ni    (dcd_n),
    .uart_rts_no    (uart_rts_no),
    .uart_dtr_no    (uart_dtr_no),
    .msr_o          (msr),
    .msr_rd_i       (msr_rd),
    .msi_o          (msi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s @cycle %0d: got 0x%02h, expected 0x%02h", tag, cyc, act, exp);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expectAt(input int sel, input int dly, input logic [7:0] val);
    sbq.push_back('{at: cyc + dly, sel: sel, val: val});
  endtask

  function automatic string selName(input int sel);
    case (sel)
      SEL_RTS: return "rts_n";
      SEL_DTR: return "dtr_n";
      SEL_MSR: return "msr";
      default: return "msi";
    endcase
  endfunction

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_RTS: return {7'b0, uart_rts_no};
      SEL_DTR: return {7'b0, uart_dtr_no};
      SEL_MSR: return msr;
      default: return {7'b0, msi};
    endcase
  endfunction

  // Monitor: pops every expectation due this cycle; grant is compared every cycle.
  always @(negedge clk) begin
    logic gnt_exp;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].at == cyc) begin
        checkOutput(selName(sbq[i].sel), observe(sbq[i].sel), sbq[i].val);
        sbq.delete(i);
      end
    end
    gnt_exp = 1'b0;
    if (gntq.size() > 0 && gntq[0] == cyc) begin
      gnt_exp = 1'b1;
      void'(gntq.pop_front());
    end
    checkOutput("gnt", {7'b0, tx_start_gnt}, {7'b0, gnt_exp});
  end

  initial begin
    rst_ni = 1'b0;
    cr_uarten = 1'b1; cr_rtsen = 1'b0; cr_ctsen = 1'b0;
    cr_rts = 1'b1; cr_dtr = 1'b1;
    cr_rx_hi = 6'd24; cr_rx_lo = 6'd8; rx_fifo_lvl = '0;
    tx_start_req = 1'b1; tx_busy = 1'b0; msr_rd = 1'b0;
    cts_n = 1'b0; dsr_n = 1'b0; ri_n = 1'b0; dcd_n = 1'b0;

    // Reset held with pins active, requests pending and software RTS/DTR asserted
    applyStimulus(3);
    expectAt(SEL_RTS, 1, 8'h01);
    expectAt(SEL_DTR, 1, 8'h01);
    expectAt(SEL_MSR, 1, 8'h00);
    expectAt(SEL_MSI, 1, 8'h00);
    applyStimulus(1);
    cts_n = 1'b1; dsr_n = 1'b1; ri_n = 1'b1; dcd_n = 1'b1;
    tx_start_req = 1'b0; cr_rts = 1'b0; cr_dtr = 1'b0;
    rst_ni = 1'b1;
    expectAt(SEL_MSR, 1, 8'h00);
    expectAt(SEL_MSR, 2, 8'h00);
    expectAt(SEL_RTS, 1, 8'h01);
    applyStimulus(3);

    // Software RTS/DTR
    cr_rts = 1'b1; cr_dtr = 1'b1;
    expectAt(SEL_RTS, 1, 8'h00);
    expectAt(SEL_DTR, 1, 8'h00);
    applyStimulus(2);
    cr_rts = 1'b0; cr_dtr = 1'b0;
    expectAt(SEL_RTS, 1, 8'h01);
    expectAt(SEL_DTR, 1, 8'h01);
    applyStimulus(2);

    // Auto-RTS hysteresis, hi=24 lo=8
    cr_rtsen = 1'b1;
    expectAt(SEL_RTS, 1, 8'h00);
    for (int l = 0; l < 24; l += 4) begin
      rx_fifo_lvl = 6'(l);
      expectAt(SEL_RTS, 1, 8'h00);
      applyStimulus(1);
    end
    rx_fifo_lvl = 6'd23;
    expectAt(SEL_RTS, 1, 8'h00);
    applyStimulus(1);
    rx_fifo_lvl = 6'd24;
    expectAt(SEL_RTS, 1, 8'h00);
    expectAt(SEL_RTS, 2, 8'h01);
    applyStimulus(3);
    rx_fifo_lvl = 6'd9;
    expectAt(SEL_RTS, 1, 8'h01);
    expectAt(SEL_RTS, 3, 8'h01);
    applyStimulus(3);
    rx_fifo_lvl = 6'd8;
    expectAt(SEL_RTS, 1, 8'h01);
    expectAt(SEL_RTS, 2, 8'h00);
    applyStimulus(3);

    // lo >= hi programmed: goes off once and must not oscillate back on
    cr_rx_hi = 6'd10; cr_rx_lo = 6'd20; rx_fifo_lvl = 6'd15;
    expectAt(SEL_RTS, 2, 8'h01);
    expectAt(SEL_RTS, 4, 8'h01);
    expectAt(SEL_RTS, 6, 8'h01);
    applyStimulus(6);
    cr_rx_hi = 6'd24; cr_rx_lo = 6'd8; rx_fifo_lvl = 6'd0;
    expectAt(SEL_RTS, 2, 8'h00);
    applyStimulus(3);

    // UART disable forces RTS_ON
    rx_fifo_lvl = 6'd30;
    expectAt(SEL_RTS, 2, 8'h01);
    applyStimulus(3);
    cr_uarten = 1'b0;
    expectAt(SEL_RTS, 1, 8'h01);
    expectAt(SEL_RTS, 2, 8'h00);
    applyStimulus(3);
    cr_uarten = 1'b1; rx_fifo_lvl = 6'd0; cr_rtsen = 1'b0;
    applyStimulus(2);

    // DSR delta and interrupt
    dsr_n = 1'b0;
    expectAt(SEL_MSR, 1, 8'h00);
    expectAt(SEL_MSR, 2, 8'h20);
    expectAt(SEL_MSR, 3, 8'h20 | (8'h02 & DM));
    expectAt(SEL_MSI, 3, 8'h00);
    expectAt(SEL_MSI, 4, MSI_V);
    applyStimulus(4);

    // MSR read coincident with the DCD delta: ddsr cleared, ddcd set
    dcd_n = 1'b0;
    applyStimulus(2);
    msr_rd = 1'b1;
    expectAt(SEL_MSR, 1, 8'hA0 | (8'h08 & DM));
    expectAt(SEL_MSI, 1, MSI_V);
    expectAt(SEL_MSI, 2, MSI_V);
    applyStimulus(1);
    msr_rd = 1'b0;
    applyStimulus(2);
    msr_rd = 1'b1;
    expectAt(SEL_MSR, 1, 8'hA0);
    expectAt(SEL_MSI, 1, MSI_V);
    expectAt(SEL_MSI, 2, 8'h00);
    applyStimulus(1);
    msr_rd = 1'b0;
    applyStimulus(2);

    // TERI only on the ring trailing edge
    ri_n = 1'b0;
    expectAt(SEL_MSR, 2, 8'hE0);
    expectAt(SEL_MSR, 3, 8'hE0);
    applyStimulus(4);
    ri_n = 1'b1;
    expectAt(SEL_MSR, 2, 8'hA0);
    expectAt(SEL_MSR, 3, 8'hA0 | (8'h04 & DM));
    expectAt(SEL_MSI, 4, MSI_V);
    applyStimulus(4);
    msr_rd = 1'b1;
    expectAt(SEL_MSR, 1, 8'hA0);
    applyStimulus(1);
    msr_rd = 1'b0;
    dsr_n = 1'b1; dcd_n = 1'b1;
    applyStimulus(4);
    msr_rd = 1'b1;
    expectAt(SEL_MSR, 1, 8'h00);
    expectAt(SEL_MSI, 2, 8'h00);
    applyStimulus(1);
    msr_rd = 1'b0;
    applyStimulus(2);

    // CTS gating: request held with CTS deasserted
    cr_ctsen = 1'b1; tx_start_req = 1'b1; tx_busy = 1'b0;
    applyStimulus(4);
    cts_n = 1'b0;
    gntq.push_back(cyc + 3);
    applyStimulus(3);
    tx_busy = 1'b1;
    applyStimulus(2);
    cts_n = 1'b1;
    applyStimulus(3);
    tx_busy = 1'b0;
    applyStimulus(5);

    // CTS back: back-to-back frames at minimum spacing
    cts_n = 1'b0;
    gntq.push_back(cyc + 3);
    gntq.push_back(cyc + 6);
    applyStimulus(6);
    tx_start_req = 1'b0;
    applyStimulus(3);

    // UART disable in TX_BUSY returns to idle; no grant while disabled
    tx_start_req = 1'b1;
    gntq.push_back(cyc + 1);
    applyStimulus(1);
    tx_busy = 1'b1;
    applyStimulus(2);
    cr_uarten = 1'b0;
    applyStimulus(4);
    cr_uarten = 1'b1;
    gntq.push_back(cyc + 1);
    applyStimulus(1);
    tx_start_req = 1'b0; tx_busy = 1'b0;
    applyStimulus(3);

    // Reset asserted mid-frame
    tx_start_req = 1'b1; cr_rts = 1'b1;
    gntq.push_back(cyc + 1);
    expectAt(SEL_RTS, 1, 8'h00);
    applyStimulus(1);
    tx_busy = 1'b1;
    applyStimulus(2);
    rst_ni = 1'b0;
    expectAt(SEL_RTS, 1, 8'h01);
    expectAt(SEL_DTR, 1, 8'h01);
    expectAt(SEL_MSR, 1, 8'h00);
    expectAt(SEL_MSI, 1, 8'h00);
    applyStimulus(3);
    tx_start_req = 1'b0; tx_busy = 1'b0; cr_rts = 1'b0;
    rst_ni = 1'b1;
    expectAt(SEL_MSR, 2, 8'h10);
    applyStimulus(4);

    checkOutput("sb_drain", 8'(sbq.size()), 8'h00);
    checkOutput("gnt_drain", 8'(gntq.size()), 8'h00);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
